// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback source-select and load-size encodings
package wb_pkg;

    typedef logic [1:0] wb_sel_t;
    typedef logic [1:0] mem_size_t;

    localparam wb_sel_t WB_ALU = 2'b00;
    localparam wb_sel_t WB_MEM = 2'b01;
    localparam wb_sel_t WB_PC4 = 2'b10;
    localparam wb_sel_t WB_IMM = 2'b11;

    localparam mem_size_t SZ_BYTE   = 2'b00;
    localparam mem_size_t SZ_HALF   = 2'b01;
    localparam mem_size_t SZ_WORD   = 2'b10;
    localparam mem_size_t SZ_DOUBLE = 2'b11;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - upstream beat handshake and payload into the writeback stage
interface wb_stage_if
    import wb_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    wb_sel_t           wb_sel;
    mem_size_t         mem_size;
    logic              mem_unsigned;
    logic [2:0]        addr_low;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic              reg_write;

    modport master (
        output in_valid, wb_sel, mem_size, mem_unsigned, addr_low,
               alu_result, mem_data, pc_plus4, imm, rd, reg_write,
        input  in_ready
    );

    modport slave (
        input  in_valid, wb_sel, mem_size, mem_unsigned, addr_low,
               alu_result, mem_data, pc_plus4, imm, rd, reg_write,
        output in_ready
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - load lane shift, size truncation and sign/zero extension
module load_align #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mem_data,
    input  logic [2:0]      addr_low,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    output logic [XLEN-1:0] load_data
);
    import wb_pkg::*;

    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] msb;
    logic            sign;

    always_comb begin
        // On a 32-bit datapath only two lane bits are meaningful.
        if (XLEN == 64) begin
            shamt = {addr_low, 3'b000};
        end else begin
            shamt = {1'b0, addr_low[1:0], 3'b000};
        end
        shifted = mem_data >> shamt;

        case (mem_size)
            SZ_BYTE: mask = XLEN'(8'hFF);
            SZ_HALF: mask = XLEN'(16'hFFFF);
            SZ_WORD: mask = XLEN'(32'hFFFF_FFFF);
            default: mask = '1;
        endcase

        // Top bit of the kept field is the sign; all-ones mask makes extension a no-op.
        msb       = mask & ~(mask >> 1);
        sign      = (|(shifted & msb)) && !mem_unsigned;
        load_data = (shifted & mask) | (sign ? ~mask : '0);
    end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - single-entry writeback stage with source select, load align and retire count
module wb_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_stage_if.slave         up,
    input  logic              flush,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic [CNT_W-1:0]  retire_cnt
);
    import wb_pkg::*;

    logic            hold_valid;
    logic            hold_reg_write;
    logic            started;
    logic            capture;
    logic            complete;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wdata_next;

    load_align #(.XLEN(XLEN)) u_load_align (
        .mem_data     (up.mem_data),
        .addr_low     (up.addr_low),
        .mem_size     (up.mem_size),
        .mem_unsigned (up.mem_unsigned),
        .load_data    (load_data)
    );

    always_comb begin
        wdata_next = up.alu_result;
        case (up.wb_sel)
            WB_MEM:  wdata_next = load_data;
            WB_PC4:  wdata_next = up.pc_plus4;
            WB_IMM:  wdata_next = up.imm;
            default: wdata_next = up.alu_result;
        endcase
    end

    assign up.in_ready = !hold_valid || rf_ready;
    // The first edge out of reset only arms the stage, so a beat left asserted through reset is not taken.
    assign capture     = started && up.in_valid && up.in_ready && !flush;
    assign complete    = hold_valid && rf_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started        <= 1'b0;
            hold_valid     <= 1'b0;
            hold_reg_write <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            retire_cnt     <= '0;
        end else begin
            started <= 1'b1;
            if (flush) begin
                hold_valid <= 1'b0;
            end else if (capture) begin
                hold_valid <= 1'b1;
            end else if (complete) begin
                hold_valid <= 1'b0;
            end
            if (capture) begin
                hold_reg_write <= up.reg_write;
                rf_waddr       <= up.rd;
                rf_wdata       <= wdata_next;
            end
            if (complete) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    // x0 writes still retire; only the strobe is suppressed.
    assign rf_we     = hold_valid && hold_reg_write && (rf_waddr != '0);
    assign fwd_valid = rf_we;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
module tb_wb_stage;
    import wb_pkg::*;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    localparam logic [63:0] ALU = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] PC4 = 64'h0000_0000_0000_1004;
    localparam logic [63:0] IMM = 64'hFFFF_FFFF_FFFF_F800;
    localparam logic [63:0] M   = 64'h8123_4567_89AB_CDEF;

    typedef struct packed {
        logic [1:0]  sel;
        logic [1:0]  sz;
        logic        uns;
        logic [2:0]  alow;
        logic [63:0] mem;
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] exp;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              rf_ready;
    logic              rf_we;
    logic              fwd_valid;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [CNT_W-1:0]  retire_cnt;
    logic [CNT_W-1:0]  exp_cnt;
    int                n_chk;
    int                n_fail;
    exp_t              sb[$];
    vec_t              vecs[14];

    wb_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) up ();

    wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (up),
        .flush      (flush),
        .rf_ready   (rf_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fwd_valid  (fwd_valid),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sel, input logic [1:0] sz, input logic uns,
                                input logic [2:0] alow, input logic [63:0] mem, input logic [4:0] rd,
                                input logic rw, input logic [63:0] exp);
        vec_t v;
        v.sel = sel; v.sz = sz; v.uns = uns; v.alow = alow;
        v.mem = mem; v.rd = rd; v.rw = rw; v.exp = exp;
        return v;
    endfunction

    task automatic set_beat(input vec_t v);
        up.wb_sel       = v.sel;
        up.mem_size     = v.sz;
        up.mem_unsigned = v.uns;
        up.addr_low     = v.alow;
        up.mem_data     = v.mem;
        up.rd           = v.rd;
        up.reg_write    = v.rw;
        up.alu_result   = ALU;
        up.pc_plus4     = PC4;
        up.imm          = IMM;
    endtask

    // Entered and left just after a rising edge, with the stage empty and rf_ready high.
    task automatic run_vec(input vec_t v, input string nm);
        logic exp_we;
        exp_we = v.rw && (v.rd != 5'd0);
        set_beat(v);
        up.in_valid = 1'b1;
        if (exp_we) sb.push_back('{v.rd, v.exp});
        @(posedge clk); #1;
        up.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_we"}, 64'(rf_we), 64'(exp_we));
        chk({nm, "_fwd"}, 64'(fwd_valid), 64'(exp_we));
        chk({nm, "_addr"}, 64'(rf_waddr), 64'(v.rd));
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1'b1;
        chk({nm, "_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_we && rf_ready && !flush) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got write rd=%0d data=%h expected none", rf_waddr, rf_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_addr", 64'(rf_waddr), 64'(e.rd));
                chk("sb_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        n_chk = 0; n_fail = 0; exp_cnt = '0;
        vecs[0]  = mk(WB_PC4, SZ_BYTE, 1'b0, 3'd0, M, 5'd5, 1'b1, 64'h0000_0000_0000_1004);
        vecs[1]  = mk(WB_MEM, SZ_BYTE, 1'b0, 3'd1, 64'h80FF, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[2]  = mk(WB_ALU, SZ_BYTE, 1'b0, 3'd0, M, 5'd1, 1'b1, 64'hDEAD_BEEF_0000_0001);
        vecs[3]  = mk(WB_IMM, SZ_BYTE, 1'b0, 3'd0, M, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_F800);
        vecs[4]  = mk(WB_MEM, SZ_HALF, 1'b1, 3'd2, M, 5'd4, 1'b1, 64'h0000_0000_0000_89AB);
        vecs[5]  = mk(WB_MEM, SZ_HALF, 1'b0, 3'd2, M, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_89AB);
        vecs[6]  = mk(WB_MEM, SZ_WORD, 1'b0, 3'd4, M, 5'd7, 1'b1, 64'hFFFF_FFFF_8123_4567);
        vecs[7]  = mk(WB_MEM, SZ_WORD, 1'b1, 3'd0, M, 5'd8, 1'b1, 64'h0000_0000_89AB_CDEF);
        vecs[8]  = mk(WB_MEM, SZ_DOUBLE, 1'b0, 3'd0, M, 5'd9, 1'b1, 64'h8123_4567_89AB_CDEF);
        vecs[9]  = mk(WB_MEM, SZ_BYTE, 1'b1, 3'd7, M, 5'd10, 1'b1, 64'h0000_0000_0000_0081);
        vecs[10] = mk(WB_MEM, SZ_HALF, 1'b0, 3'd7, M, 5'd11, 1'b1, 64'h0000_0000_0000_0081);
        vecs[11] = mk(WB_MEM, SZ_BYTE, 1'b0, 3'd3, M, 5'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FF89);
        vecs[12] = mk(WB_ALU, SZ_BYTE, 1'b0, 3'd0, M, 5'd0, 1'b1, 64'h0);
        vecs[13] = mk(WB_ALU, SZ_BYTE, 1'b0, 3'd0, M, 5'd13, 1'b0, 64'h0);

        rst_n = 1'b0; flush = 1'b0; rf_ready = 1'b1;
        up.in_valid = 1'b0;
        set_beat(vecs[2]);
        #12;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_addr", 64'(rf_waddr), 64'd0);
        chk("rst_data", rf_wdata, 64'd0);
        chk("rst_cnt", 64'(retire_cnt), 64'd0);
        chk("rst_rdy", 64'(up.in_ready), 64'd1);

        // Beat held through reset release must not be taken on the first edge.
        set_beat(mk(WB_ALU, SZ_BYTE, 1'b0, 3'd0, M, 5'd7, 1'b1, 64'h0));
        up.in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        up.in_valid = 1'b0;
        chk("first_edge_we", 64'(rf_we), 64'd0);
        chk("first_edge_cnt", 64'(retire_cnt), 64'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Stall: held beat must stay put for three cycles.
        rf_ready = 1'b0;
        set_beat(mk(WB_ALU, SZ_BYTE, 1'b0, 3'd0, M, 5'd14, 1'b1, 64'h0));
        up.in_valid = 1'b1;
        sb.push_back('{5'd14, ALU});
        @(posedge clk); #1;
        set_beat(mk(WB_IMM, SZ_BYTE, 1'b0, 3'd0, M, 5'd20, 1'b1, 64'h0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdy", 64'(up.in_ready), 64'd0);
            chk("stall_we", 64'(rf_we), 64'd1);
            chk("stall_addr", 64'(rf_waddr), 64'd14);
            chk("stall_data", rf_wdata, ALU);
        end
        @(posedge clk); #1;
        up.in_valid = 1'b0;
        rf_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1'b1;
        chk("stall_cnt", 64'(retire_cnt), 64'(exp_cnt));
        chk("stall_done_we", 64'(rf_we), 64'd0);

        // Flush with a held beat and a competing incoming beat.
        rf_ready = 1'b0;
        set_beat(mk(WB_ALU, SZ_BYTE, 1'b0, 3'd0, M, 5'd15, 1'b1, 64'h0));
        up.in_valid = 1'b1;
        @(posedge clk); #1;
        set_beat(mk(WB_IMM, SZ_BYTE, 1'b0, 3'd0, M, 5'd16, 1'b1, 64'h0));
        flush = 1'b1;
        rf_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        up.in_valid = 1'b0;
        chk("flush_we", 64'(rf_we), 64'd0);
        chk("flush_rdy", 64'(up.in_ready), 64'd1);
        chk("flush_cnt", 64'(retire_cnt), 64'(exp_cnt));
        @(posedge clk); #1;
        chk("flush_cnt2", 64'(retire_cnt), 64'(exp_cnt));
        chk("flush_we2", 64'(rf_we), 64'd0);

        // Reset pulsed mid-stall clears everything at once.
        rf_ready = 1'b0;
        set_beat(mk(WB_PC4, SZ_BYTE, 1'b0, 3'd0, M, 5'd17, 1'b1, 64'h0));
        up.in_valid = 1'b1;
        @(posedge clk); #1;
        up.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_we", 64'(rf_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_fwd", 64'(fwd_valid), 64'd0);
        chk("mid_rst_addr", 64'(rf_waddr), 64'd0);
        chk("mid_rst_data", rf_wdata, 64'd0);
        chk("mid_rst_cnt", 64'(retire_cnt), 64'd0);
        chk("mid_rst_rdy", 64'(up.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rf_ready = 1'b1;
        exp_cnt = '0;
        @(posedge clk); #1;
        chk("post_rst_we", 64'(rf_we), 64'd0);

        // 17 back-to-back completions wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            set_beat(mk(WB_ALU, SZ_BYTE, 1'b0, 3'd0, M, 5'(i + 1), 1'b1, 64'h0));
            up.alu_result = 64'h100 + 64'(i);
            up.in_valid = 1'b1;
            sb.push_back('{5'(i + 1), 64'h100 + 64'(i)});
            @(posedge clk); #1;
        end
        up.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wrap_cnt", 64'(retire_cnt), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width (32 or 64 only).
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL have parameter CNT_W, default 32, meaning retire-counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-008 SHALL have port flush  input  1  discard held and incoming beats.
REQ-009 SHALL have port wb_sel  input  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
REQ-010 SHALL have port mem_size  input  2  load size: 00 byte, 01 half, 10 word, 11 double.
REQ-011 SHALL have port mem_unsigned  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-012 SHALL have port addr_low  input  3  low address bits, selecting the byte lane.
REQ-013 SHALL have ports alu_result, mem_data, pc_plus4 and imm  input  XLEN  candidate sources.
REQ-014 SHALL have port rd  input  REG_AW  destination register.
REQ-015 SHALL have port reg_write  input  1  instruction writes rd.
REQ-016 SHALL have port rf_ready  input  1  register file accepts a write this cycle.
REQ-017 SHALL have port rf_we  output  1  write strobe.
REQ-018 SHALL have port rf_waddr  output  REG_AW  write address.
REQ-019 SHALL have port rf_wdata  output  XLEN  write data.
REQ-020 SHALL have port fwd_valid  output  1  held beat writes a nonzero rd (bypass qualifier).
REQ-021 SHALL have port retire_cnt  output  CNT_W  count of completed beats.

Function
REQ-022 SHALL capture a beat on a rising edge when in_valid && in_ready && !flush; latency from capture to rf_* is exactly 1 cycle.
REQ-023 SHALL compute in_ready = !hold_valid || rf_ready, combinationally.
REQ-024 SHALL complete a held beat when hold_valid && rf_ready; capturing a new beat in the same cycle is permitted (full throughput).
REQ-025 SHALL keep rf_waddr and rf_wdata stable while hold_valid && !rf_ready.
REQ-026 SHALL drive rf_we = hold_valid && hold_reg_write && (hold_rd != 0); a write to x0 SHALL be suppressed but SHALL still complete and count.
REQ-027 SHALL, for MEM, shift mem_data right by 8*addr_low (addr_low[2] ignored when XLEN=32), truncate to size and extend per mem_unsigned.
REQ-028 SHALL treat mem_size=11 as word when XLEN=32; a misaligned lane SHALL yield the shifted bytes with no trap.
REQ-029 SHALL perform source select and load extension before the register, so rf_wdata is a direct register output.
REQ-030 SHALL, on flush, clear hold_valid on the next edge and capture nothing that cycle; flush overrides in_valid and rf_ready.
REQ-031 SHALL increment retire_cnt by 1 on each completion (hold_valid && rf_ready && !flush), wrapping modulo 2^CNT_W.
REQ-032 SHALL drive fwd_valid = rf_we.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force hold_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0 and retire_cnt=0; in_ready therefore reads 1.
REQ-034 SHALL drop an in-flight beat when reset is asserted mid-operation, with no write issued.
REQ-035 SHALL capture nothing on the first edge at which rst_n is already high.

Structure
REQ-036 SHALL take wb_sel and mem_size encodings from a shared package (wb_pkg) as named constants, reused by decode.
REQ-037 SHALL place the load align/extend logic in one combinational sub-module, load_align (XLEN parameter).

Verification
REQ-038 SHALL cover: XLEN=64, wb_sel=01, mem_data=0x00000000_0000_80FF, addr_low=1, byte signed -> rf_wdata=0xFFFF_FFFF_FFFF_FF80 one cycle later.
REQ-039 SHALL cover: wb_sel=10, pc_plus4=0x1004, rd=5, reg_write=1 -> rf_we=1, rf_waddr=5, rf_wdata=0x1004, retire_cnt 0->1.
REQ-040 SHALL cover: rd=0, reg_write=1 -> rf_we=0, retire_cnt still increments.
REQ-041 SHALL cover: rf_ready=0 for 3 cycles with a held beat -> in_ready=0, rf_* unchanged, then one completion when rf_ready=1.
REQ-042 SHALL cover: flush asserted together with in_valid and a held beat -> next cycle hold_valid=0, no rf_we, retire_cnt unchanged.
REQ-043 SHALL cover: CNT_W=4 and 17 completions -> retire_cnt=1; rst_n pulsed mid-stall -> all outputs 0 immediately.
